// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl: decode->execute sequencer (hold/bubble/flush, forwarding, load-use, branch, mem-wait, perf counters)
// in:  decode sources, EX/MEM/WB destinations, branch resolution, data-memory req/ack
// out: hold_f/hold_d/hold_m, bubble_d, flush_f, fwd_rs1/fwd_rs2, state, stall_cnt, flush_cnt
module decode_hazard_ctrl #(
  parameter int REDIRECT_CYCLES = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_wb_en,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic             mem_wb_en,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             wb_wb_en,
  output logic             hold_f,
  output logic             hold_d,
  output logic             hold_m,
  output logic             bubble_d,
  output logic             flush_f,
  output logic [1:0]       fwd_rs1,
  output logic [1:0]       fwd_rs2,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, MEMWAIT = 2'd1, REDIRECT = 2'd2} state_t;
  state_t st, st_n;
  logic [2:0] rc, rc_n;
  logic mem_stall, lu, br, br_fire;
  function automatic logic [1:0] src(input logic [4:0] s);
    return s == 5'd0 ? 2'd0 :
           (ex_valid && ex_wb_en && !ex_is_load && ex_rd == s) ? 2'd1 :
           (mem_valid && mem_wb_en && mem_rd == s) ? 2'd2 :
           (wb_valid && wb_wb_en && wb_rd == s) ? 2'd3 : 2'd0;
  endfunction
  assign mem_stall = !mem_ack && (mem_req || st == MEMWAIT);
  assign lu = dec_valid && ex_valid && ex_is_load && ex_rd != 5'd0 &&
              ((dec_use_rs1 && dec_rs1 == ex_rd) || (dec_use_rs2 && dec_rs2 == ex_rd));
  assign br = ex_valid && ex_br_taken;
  assign fwd_rs1 = reset ? 2'd0 : src(dec_rs1);
  assign fwd_rs2 = reset ? 2'd0 : src(dec_rs2);
  assign state = st;
  always_comb begin
    hold_f = 1'b0;
    hold_d = 1'b0;
    hold_m = 1'b0;
    bubble_d = 1'b0;
    flush_f = 1'b0;
    br_fire = 1'b0;
    st_n = RUN;
    rc_n = rc;
    if (reset) begin
      flush_f = 1'b1;
      bubble_d = 1'b1;
      rc_n = 3'd0;
    end else if (mem_stall) begin
      hold_f = 1'b1;
      hold_d = 1'b1;
      hold_m = 1'b1;
      st_n = st == REDIRECT ? REDIRECT : MEMWAIT;
    end else if (br) begin
      flush_f = 1'b1;
      bubble_d = 1'b1;
      br_fire = 1'b1;
      st_n = REDIRECT_CYCLES == 0 ? RUN : REDIRECT;
      rc_n = 3'(REDIRECT_CYCLES);
    end else if (st == REDIRECT) begin
      flush_f = 1'b1;
      bubble_d = 1'b1;
      st_n = rc > 3'd1 ? REDIRECT : RUN;
      rc_n = rc > 3'd1 ? rc - 3'd1 : 3'd0;
    end else if (lu) begin
      hold_f = 1'b1;
      bubble_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= RUN;
      rc <= 3'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      st <= st_n;
      rc <= rc_n;
      if (hold_f && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_fire && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule
